// File: rtl/instr_encoder_loader.sv
// Packs R/I/J/raw instruction fields into 32-bit MIPS words and streams them
// into consecutive instruction-memory words behind a one-entry output register.
module instr_encoder_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_fmt,
    input  logic [5:0]            in_opcode,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [31:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err_range,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  err_range_q, err_range_d;
    logic [31:0]           acc_cnt_q, acc_cnt_d;

    logic        in_ready_c;
    logic        accept;
    logic        complete;
    logic [31:0] enc_word;
    logic        imm_ovf;

    always_comb begin
        enc_word = in_imm;
        unique case (in_fmt)
            2'd0:    enc_word = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
            2'd1:    enc_word = {in_opcode, in_rs, in_rt, in_imm[15:0]};
            2'd2:    enc_word = {in_opcode, in_target};
            default: enc_word = in_imm;
        endcase
        // Fits 16-bit signed only when bits [31:15] are a pure sign extension.
        imm_ovf = !((&in_imm[31:15]) || !(|in_imm[31:15]));
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        count_d     = count_q;
        err_range_d = err_range_q;
        acc_cnt_d   = acc_cnt_q;
        in_ready_c  = 1'b0;
        complete    = mem_we_q && mem_ready;

        if (complete) begin
            mem_we_d = 1'b0;
            count_d  = count_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    wr_ptr_d    = ADDR_WIDTH'(BASE_ADDR);
                    count_d     = '0;
                    acc_cnt_d   = '0;
                    err_range_d = 1'b0;
                end
            end
            S_LOAD: begin
                in_ready_c = !mem_we_q || mem_ready;
            end
            S_DRAIN: begin
                if (complete) begin
                    state_d = S_DONE;
                end
            end
        endcase

        // A completion and a fresh accept in one cycle simply reload the register.
        accept = in_valid && in_ready_c;
        if (accept) begin
            mem_wdata_d = enc_word;
            mem_addr_d  = wr_ptr_q;
            mem_we_d    = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            acc_cnt_d   = acc_cnt_q + 32'd1;
            if (in_fmt == 2'd1 && imm_ovf) begin
                err_range_d = 1'b1;
            end
            if (in_last || (acc_cnt_q + 32'd1 == MAX_WORDS)) begin
                state_d = S_DRAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            count_q     <= '0;
            err_range_q <= 1'b0;
            acc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            count_q     <= count_d;
            err_range_q <= err_range_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign err_range = err_range_q;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: default instance for encoding/backpressure/streaming, and a
// small instance (3-bit address, base 6, 4-word limit) for limit and wrap.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        in_valid;
    logic [1:0]  in_fmt;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [31:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;
    logic        mem_ready;

    logic        a_in_ready, a_mem_we, a_err, a_done;
    logic [9:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [10:0] a_count;

    logic        b_in_ready, b_mem_we, b_err, b_done;
    logic [2:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [3:0]  b_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    instr_encoder_loader dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_ready(mem_ready), .count(a_count), .err_range(a_err), .done(a_done)
    );

    instr_encoder_loader #(.ADDR_WIDTH(3), .BASE_ADDR(6), .MAX_WORDS(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ready(mem_ready), .count(b_count), .err_range(b_err), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [1:0] fmt, input logic [5:0] op,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh,
                              input logic [5:0] fn, input logic [31:0] imm,
                              input logic [25:0] tgt, input logic last);
        in_fmt    = fmt;
        in_opcode = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = sh;
        in_funct  = fn;
        in_imm    = imm;
        in_target = tgt;
        in_last   = last;
    endtask

    task automatic set_raw(input logic [31:0] w, input logic last);
        set_fields(2'd3, '0, '0, '0, '0, '0, '0, w, '0, last);
    endtask

    // Present one tuple for a single accepting cycle, then drop in_valid.
    task automatic issue(input logic [1:0] fmt, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh,
                         input logic [5:0] fn, input logic [31:0] imm,
                         input logic [25:0] tgt, input logic last);
        set_fields(fmt, op, rs, rt, rd, sh, fn, imm, tgt, last);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mem_ready = 1'b1;
        in_valid = 1'b1;
        set_raw(32'h0, 1'b0);

        // 1: reset with in_valid high
        tick(); tick();
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_mem_we",   32'(a_mem_we),   32'd0);
        check("rst_done",     32'(a_done),     32'd0);
        check("rst_err",      32'(a_err),      32'd0);
        check("rst_addr",     32'(a_mem_addr), 32'd0);
        check("rst_wdata",    a_mem_wdata,     32'd0);
        check("rst_count",    32'(a_count),    32'd0);
        rst = 1'b0;
        tick();
        check("idle_ignores_valid", 32'(a_mem_we), 32'd0);
        in_valid = 1'b0;

        // 2: R-type
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("load_in_ready", 32'(a_in_ready), 32'd1);
        issue(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'h0, 26'h0, 1'b0);
        check("r_we",    32'(a_mem_we),   32'd1);
        check("r_addr",  32'(a_mem_addr), 32'd0);
        check("r_wdata", a_mem_wdata,     32'h00221820);
        tick();
        check("r_count", 32'(a_count), 32'd1);
        check("r_we_clr", 32'(a_mem_we), 32'd0);

        // 3: I-type in range, then out of range
        issue(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 32'hFFFF_FFFF, 26'h0, 1'b0);
        check("i_addr",  32'(a_mem_addr), 32'd1);
        check("i_wdata", a_mem_wdata,     32'h2008FFFF);
        check("i_err0",  32'(a_err),      32'd0);
        tick();
        issue(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 32'h0000_8000, 26'h0, 1'b0);
        check("i_ovf_wdata", a_mem_wdata, 32'h20088000);
        check("i_err1",      32'(a_err),  32'd1);
        tick();

        // 4: J-type and raw
        issue(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 26'h0100000, 1'b0);
        check("j_addr",  32'(a_mem_addr), 32'd3);
        check("j_wdata", a_mem_wdata,     32'h08100000);
        tick();
        issue(2'd3, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 32'hDEADBEEF, 26'h0, 1'b0);
        check("raw_wdata", a_mem_wdata, 32'hDEADBEEF);
        check("err_sticky", 32'(a_err), 32'd1);
        tick();
        check("count_5", 32'(a_count), 32'd5);

        // 5a: backpressure, then completion and accept in the same cycle
        mem_ready = 1'b0;
        set_raw(32'h1111_1111, 1'b0);
        in_valid = 1'b1;
        tick();
        set_raw(32'h2222_2222, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
            check("bp_we",       32'(a_mem_we),   32'd1);
            check("bp_addr",     32'(a_mem_addr), 32'd5);
            check("bp_wdata",    a_mem_wdata,     32'h11111111);
        end
        check("bp_count", 32'(a_count), 32'd5);
        mem_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(a_in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("nobubble_we",    32'(a_mem_we),   32'd1);
        check("nobubble_addr",  32'(a_mem_addr), 32'd6);
        check("nobubble_wdata", a_mem_wdata,     32'h22222222);
        check("nobubble_count", 32'(a_count),    32'd6);
        check("drain_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        check("s1_done",  32'(a_done),   32'd1);
        check("s1_count", 32'(a_count),  32'd7);
        check("s1_we",    32'(a_mem_we), 32'd0);

        // 5b: new session, 8 back-to-back tuples
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("s2_err_clr",   32'(a_err),   32'd0);
        check("s2_count_clr", 32'(a_count), 32'd0);
        check("s2_done_clr",  32'(a_done),  32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_raw(32'hA000_0000 + 32'(i), (i == 7));
            tick();
            check("stream_we",    32'(a_mem_we),   32'd1);
            check("stream_addr",  32'(a_mem_addr), 32'(i));
            check("stream_wdata", a_mem_wdata,     32'hA000_0000 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("s2_done",  32'(a_done),  32'd1);
        check("s2_count", 32'(a_count), 32'd8);

        // 6: word limit and address wrap on the small instance
        start_b = 1'b1; tick(); start_b = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_raw(32'h0000_00B0 + 32'(i), 1'b0);
            tick();
            check("lim_we",   32'(b_mem_we),   32'd1);
            check("lim_addr", 32'(b_mem_addr), 32'((6 + i) % 8));
        end
        set_raw(32'h0000_00B4, 1'b0);
        check("lim_in_ready", 32'(b_in_ready), 32'd0);
        tick();
        check("lim_done",  32'(b_done),   32'd1);
        check("lim_count", 32'(b_count),  32'd4);
        check("lim_we",    32'(b_mem_we), 32'd0);
        tick();
        check("lim_count_hold", 32'(b_count),  32'd4);
        check("lim_wdata_hold", b_mem_wdata,   32'h000000B3);
        in_valid = 1'b0;

        start_b = 1'b1; tick(); start_b = 1'b0;
        set_raw(32'h0000_00C0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst_mid_we",   32'(b_mem_we),   32'd1);
        check("rst_mid_addr", 32'(b_mem_addr), 32'd6);
        rst = 1'b1;
        tick();
        check("rst_mid_we0",    32'(b_mem_we),   32'd0);
        check("rst_mid_ready",  32'(b_in_ready), 32'd0);
        check("rst_mid_count",  32'(b_count),    32'd0);
        check("rst_mid_done",   32'(b_done),     32'd0);
        rst = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_idle_we", 32'(b_mem_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
